// File: rtl/thor2022_irq_pic.sv
// Programmable interrupt controller: up to 32 prioritised edge/level sources,
// a memory-mapped register file and an IDLE/ASSERT/INSERVICE handshake with the CPU.
module thor2022_irq_pic #(
    parameter int unsigned NSRC = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [9:0]  adr_i,
    input  logic [63:0] dat_i,
    output logic [63:0] dat_o,
    output logic        ack_o,
    input  logic [31:0] irq_i,
    output logic        irq_o,
    output logic [4:0]  cause_o,
    output logic [2:0]  level_o,
    input  logic        iack_i
);

    // Bits at or above NSRC do not exist and always read 0.
    localparam logic [31:0] SrcMask = 32'((64'd1 << NSRC) - 64'd1);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StInService
    } state_e;

    // Bus decode
    logic        cs;
    logic        wr;
    logic        rd;
    logic [6:0]  widx;
    logic        wr_en;
    logic        wr_edge;
    logic        wr_pend;
    logic        wr_eoi;
    logic        wr_thr;
    logic        wr_pri;

    // Register file and source state
    logic [31:0] enable_q;
    logic [31:0] enable_d;
    logic [31:0] edge_mask_q;
    logic [31:0] edge_mask_d;
    logic [31:0] pend_edge_q;
    logic [31:0] pend_edge_d;
    logic [31:0] irq_q;
    logic [2:0]  threshold_q;
    logic [2:0]  pri_q [NSRC];

    logic [31:0] edge_det;
    logic [31:0] w1c;
    logic [31:0] iack_clr;
    logic [31:0] pending;

    // Candidate selection
    logic        best_valid;
    logic [4:0]  best_id;
    logic [2:0]  best_pri;
    logic        cand_valid_q;
    logic [4:0]  cand_id_q;
    logic [2:0]  cand_pri_q;

    // Handshake FSM
    state_e      state_q;
    state_e      state_d;
    logic [4:0]  cause_q;
    logic [4:0]  cause_d;
    logic [2:0]  level_q;
    logic [2:0]  level_d;
    logic [4:0]  is_id_q;
    logic [4:0]  is_id_d;
    logic [2:0]  is_pri_q;
    logic [2:0]  is_pri_d;

    // Read path
    logic [8:0]  status;
    logic [31:0] rd_data;
    logic [31:0] dat_q;
    logic        rd_ack_q;

    logic        unused_bits;
    assign unused_bits = ^{dat_i[63:32], adr_i[2:0]};

    assign cs      = cs_i & cyc_i & stb_i;
    assign wr      = cs & we_i;
    assign rd      = cs & ~we_i;
    assign widx    = adr_i[9:3];
    assign wr_en   = wr && (widx == 7'd0);
    assign wr_edge = wr && (widx == 7'd1);
    assign wr_pend = wr && (widx == 7'd2);
    assign wr_eoi  = wr && (widx == 7'd3);
    assign wr_thr  = wr && (widx == 7'd4);
    assign wr_pri  = wr && (widx[6:5] == 2'b01);

    assign enable_d    = wr_en ? (dat_i[31:0] & SrcMask) : enable_q;
    assign edge_mask_d = wr_edge ? (dat_i[31:0] & SrcMask) : edge_mask_q;

    assign edge_det = irq_i & ~irq_q & SrcMask;
    assign w1c      = wr_pend ? dat_i[31:0] : 32'd0;
    assign iack_clr = (state_q == StAssert && iack_i) ? (32'd1 << cause_q) : 32'd0;

    // A fresh edge overrides any clear in the same cycle; disabling or
    // switching a source to level mode drops its latched request at once.
    assign pend_edge_d = ((pend_edge_q & ~w1c & ~iack_clr) | edge_det) & enable_d & edge_mask_d;

    assign pending = (edge_mask_q & pend_edge_q) | (~edge_mask_q & irq_q & enable_q);

    assign status  = (state_q == StInService) ? {1'b1, is_pri_q, is_id_q} : 9'd0;
    assign irq_o   = (state_q == StAssert);
    assign cause_o = cause_q;
    assign level_o = level_q;
    assign ack_o   = wr | rd_ack_q;
    assign dat_o   = {32'd0, dat_q};

    // Register read multiplexer
    always_comb begin
        rd_data = 32'd0;
        case (widx)
            7'd0: rd_data = enable_q;
            7'd1: rd_data = edge_mask_q;
            7'd2: rd_data = pending;
            7'd3: rd_data[8:0] = status;
            7'd4: rd_data[2:0] = threshold_q;
            default: begin
                if (widx[6:5] == 2'b01 && 32'(widx[4:0]) < NSRC) begin
                    rd_data[2:0] = pri_q[widx[4:0]];
                end
            end
        endcase
    end

    // Highest qualifying priority wins; scanning downward with >= leaves the lowest id on ties
    always_comb begin
        best_valid = 1'b0;
        best_id    = 5'd0;
        best_pri   = 3'd0;
        for (int n = int'(NSRC) - 1; n >= 0; n--) begin
            if (pending[n] && (pri_q[n] > threshold_q) &&
                (!best_valid || (pri_q[n] >= best_pri))) begin
                best_valid = 1'b1;
                best_id    = 5'(n);
                best_pri   = pri_q[n];
            end
        end
    end

    // Bus acknowledge and registered read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ack_q <= 1'b0;
            dat_q    <= 32'd0;
        end else begin
            rd_ack_q <= rd;
            dat_q    <= rd ? rd_data : 32'd0;
        end
    end

    // Mask, threshold, pending and input sampling registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= 32'd0;
            edge_mask_q <= 32'd0;
            pend_edge_q <= 32'd0;
            irq_q       <= 32'd0;
            threshold_q <= 3'd0;
        end else begin
            enable_q    <= enable_d;
            edge_mask_q <= edge_mask_d;
            pend_edge_q <= pend_edge_d;
            irq_q       <= irq_i & SrcMask;
            if (wr_thr) begin
                threshold_q <= dat_i[2:0];
            end
        end
    end

    // Per-source priority registers
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < int'(NSRC); n++) begin
            if (rst_i) begin
                pri_q[n] <= 3'd0;
            end else if (wr_pri && widx[4:0] == 5'(n)) begin
                pri_q[n] <= dat_i[2:0];
            end
        end
    end

    // Registered candidate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand_valid_q <= 1'b0;
            cand_id_q    <= 5'd0;
            cand_pri_q   <= 3'd0;
        end else begin
            cand_valid_q <= best_valid;
            cand_id_q    <= best_id;
            cand_pri_q   <= best_pri;
        end
    end

    // Handshake next-state: assert, acknowledge into service, end of interrupt
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        level_d  = level_q;
        is_id_d  = is_id_q;
        is_pri_d = is_pri_q;
        case (state_q)
            StIdle: begin
                if (cand_valid_q) begin
                    state_d = StAssert;
                    cause_d = cand_id_q;
                    level_d = cand_pri_q;
                end
            end
            StAssert: begin
                if (iack_i) begin
                    state_d  = StInService;
                    is_id_d  = cause_q;
                    is_pri_d = level_q;
                end else if (!cand_valid_q) begin
                    state_d = StIdle;
                end else begin
                    cause_d = cand_id_q;
                    level_d = cand_pri_q;
                end
            end
            StInService: begin
                if (wr_eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cause_q  <= 5'd0;
            level_q  <= 3'd0;
            is_id_q  <= 5'd0;
            is_pri_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            level_q  <= level_d;
            is_id_q  <= is_id_d;
            is_pri_q <= is_pri_d;
        end
    end

endmodule
